i2s_fifo_drain_ctrl: RTL
========================

# i2s_fifo_drain_ctrl

Read-side controller for the I2S sample FIFO. Pops one sample at a time from the FIFO when it is non-empty and draining is enabled, then serializes each sample MSB-byte-first onto a byte-wide valid/ready stream that feeds the SPI transmit path. It is the only agent that drives the FIFO read enable. It never reads an empty FIFO and never drops a byte under backpressure.

## Interface
- `SAMPLE_WIDTH`, default 24: FIFO word width in bits. Must be a multiple of 8 and at least 8.
- `FRAME_SAMPLES`, default 4: number of samples per frame. Used only with the header feature.
- `clk` input, 1 bit: single clock, all state on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `enable_i` input, 1 bit: allows new pops. Sampled only at sample boundaries.
- `fifo_empty_i` input, 1 bit: FIFO empty flag.
- `fifo_rd_en_o` output, 1 bit: FIFO read strobe. The FIFO registers its read data on this edge.
- `fifo_data_i` input, `SAMPLE_WIDTH` bits: FIFO registered read data.
- `byte_o` output, 8 bits: outgoing byte.
- `byte_valid_o` output, 1 bit: `byte_o` is valid.
- `byte_ready_i` input, 1 bit: consumer accepts the byte.
- `busy_o` output, 1 bit: high whenever the state is not IDLE.
- `sample_count_o` output, 16 bits: count of fully transmitted samples. Wraps modulo 2^16.

## Operation
- `BYTES = SAMPLE_WIDTH/8`. An internal byte counter is `$clog2(BYTES)+1` bits wide.
- States and actions:
  - IDLE: no outputs asserted. Leaves to POP when `enable_i && !fifo_empty_i`, or to HEADER when the header is due.
  - POP: `fifo_rd_en_o=1` for exactly this cycle, then go to LATCH.
  - LATCH: capture `fifo_data_i` into the shift register, load byte counter = `BYTES`, then go to SEND.
  - SEND: `byte_valid_o=1`, `byte_o` = shift register bits [SW-1:SW-8].
- Handshake in SEND:
  - On `byte_valid_o && byte_ready_i`: shift left by 8 and decrement the byte counter.
  - After the last byte: increment `sample_count_o`, then re-evaluate the IDLE condition in the same cycle. If it holds, go straight to POP (or HEADER when due); otherwise go to IDLE.
- `fifo_rd_en_o` is asserted only in POP, and POP is entered only after `fifo_empty_i` was sampled low. A read strobe to an empty FIFO is therefore impossible.
- Deasserting `enable_i` mid-sample has no effect until the current sample finishes. The block then stops at the sample boundary.
- `fifo_empty_i` changing during LATCH or SEND is ignored until the next boundary.
- Reset mid-operation (async): all state returns to IDLE, all outputs go to 0, and the partially sent sample is lost. The popped word is not re-read.
- Reset values: `fifo_rd_en_o=0`, `byte_o=8'h00`, `byte_valid_o=0`, `busy_o=0`, `sample_count_o=0`.

## Timing
- Start-up latency: the cycle in which IDLE sees the start condition is cycle 0. POP is cycle 1, LATCH is cycle 2, and the first `byte_valid_o` is cycle 3.
- Throughput with `byte_ready_i` held at 1: `BYTES+2` cycles per sample, i.e. 5 cycles for 24-bit samples. Each sample spends BYTES cycles in SEND, plus one cycle each in POP and LATCH.
- While `byte_valid_o && !byte_ready_i`, `byte_o` and `byte_valid_o` hold stable. There is no limit on stall length.
- `byte_valid_o` never drops without a handshake, except on reset.
- `sample_count_o` updates on the edge that accepts the final byte of a sample.

## Configuration
- Macro `I2S_DRAIN_SYNC_HEADER_EN`.
- Defined:
  - A sync byte `8'hA5` is emitted through state HEADER (`byte_valid_o=1`, same handshake rules) before sample 0 of every frame of `FRAME_SAMPLES` samples.
  - HEADER is entered from IDLE or from the end of SEND, only when the start condition holds, and is followed by POP.
  - A 16-bit-wide frame sample index resets to 0 on reset and after the last sample of each frame.
  - `sample_count_o` does not count header bytes.
- Undefined: the HEADER state, the `8'hA5` sync byte and the frame index are absent, `FRAME_SAMPLES` is ignored, and the output is a pure sample byte stream.

## Test plan
- Reset behaviour: FIFO holds `24'h123456`, `enable_i=1`, ready=1. Expected response:
  - `fifo_rd_en_o` high exactly 1 cycle after the start cycle.
  - Bytes `12`, `34`, `56` appear on cycles 3, 4 and 5.
  - `sample_count_o=1`.
- Back-to-back samples: FIFO holds `AABBCC`, `DDEEFF`, ready=1. Expected: six bytes in order, one gap of 2 cycles between samples, `sample_count_o=2`, then IDLE with `busy_o=0`.
- Backpressure: ready low for 10 cycles on byte 2 of `24'h010203`. Expected: `byte_o=8'h02` held stable with valid high, no extra `fifo_rd_en_o`, and byte 3 follows release.
- Enable drop mid-sample: `enable_i` falls after byte 1 while the FIFO holds 3 words. Expected: the current sample completes, no further pops, and 2 words remain in the FIFO.
- Async reset mid-SEND: `rst_n` low during byte 2. Expected: all outputs 0 immediately (no clock edge needed), `sample_count_o=0`, and IDLE after release.
- With `I2S_DRAIN_SYNC_HEADER_EN` defined and `FRAME_SAMPLES=2`, 4 samples queued: stream = `A5`, s0, s1, `A5`, s2, s3, and `sample_count_o=4`.

Source files
------------

// File: rtl/i2s_fifo_drain_ctrl.sv
// Read-side drain controller for the I2S sample FIFO: pops one word at a time and
// streams it MSB-byte-first on a valid/ready byte port. Optional frame sync byte: I2S_DRAIN_SYNC_HEADER_EN.
module i2s_fifo_drain_ctrl #(
    parameter int unsigned SAMPLE_WIDTH  = 24,
    parameter int unsigned FRAME_SAMPLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    fifo_empty_i,
    output logic                    fifo_rd_en_o,
    input  logic [SAMPLE_WIDTH-1:0] fifo_data_i,
    output logic [7:0]              byte_o,
    output logic                    byte_valid_o,
    input  logic                    byte_ready_i,
    output logic                    busy_o,
    output logic [15:0]             sample_count_o
);

    localparam int unsigned BYTES = SAMPLE_WIDTH / 8;
    localparam int unsigned CW    = $clog2(BYTES) + 1;

    if ((SAMPLE_WIDTH % 8) != 0 || SAMPLE_WIDTH < 8 || FRAME_SAMPLES < 1) begin : g_bad_param
        $error("i2s_fifo_drain_ctrl: SAMPLE_WIDTH must be a multiple of 8 (>=8), FRAME_SAMPLES >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_SEND
`ifdef I2S_DRAIN_SYNC_HEADER_EN
        , ST_HEADER
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [15:0]             count_q, count_d;
    logic                    start;

`ifdef I2S_DRAIN_SYNC_HEADER_EN
    logic [15:0] frame_q, frame_d, frame_next;
    logic        due_idle, due_next;

    always_comb begin
        frame_next = (frame_q == 16'(FRAME_SAMPLES - 1)) ? '0 : frame_q + 16'd1;
        due_idle   = (frame_q == '0);
        due_next   = (frame_next == '0);
    end
`endif

    assign start          = enable_i && !fifo_empty_i;
    assign busy_o         = (state_q != ST_IDLE);
    assign sample_count_o = count_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        count_d      = count_q;
        fifo_rd_en_o = 1'b0;
        byte_valid_o = 1'b0;
        byte_o       = '0;
`ifdef I2S_DRAIN_SYNC_HEADER_EN
        frame_d      = frame_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef I2S_DRAIN_SYNC_HEADER_EN
                    state_d = due_idle ? ST_HEADER : ST_POP;
`else
                    state_d = ST_POP;
`endif
                end
            end
`ifdef I2S_DRAIN_SYNC_HEADER_EN
            ST_HEADER: begin
                byte_valid_o = 1'b1;
                byte_o       = 8'hA5;
                if (byte_ready_i) begin
                    state_d = ST_POP;
                end
            end
`endif
            ST_POP: begin
                fifo_rd_en_o = 1'b1;
                state_d      = ST_LATCH;
            end
            ST_LATCH: begin
                shift_d = fifo_data_i;
                cnt_d   = CW'(BYTES);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                byte_valid_o = 1'b1;
                byte_o       = shift_q[SAMPLE_WIDTH-1 -: 8];
                if (byte_ready_i) begin
                    shift_d = shift_q << 8;
                    cnt_d   = cnt_q - 1'b1;
                    // Final byte: the boundary decision is made here so the next pop
                    // follows immediately without an IDLE bubble.
                    if (cnt_q == CW'(1)) begin
                        count_d = count_q + 16'd1;
`ifdef I2S_DRAIN_SYNC_HEADER_EN
                        frame_d = frame_next;
                        if (start) begin
                            state_d = due_next ? ST_HEADER : ST_POP;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = start ? ST_POP : ST_IDLE;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            count_q <= '0;
`ifdef I2S_DRAIN_SYNC_HEADER_EN
            frame_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
`ifdef I2S_DRAIN_SYNC_HEADER_EN
            frame_q <= frame_d;
`endif
        end
    end

endmodule
